// File: rtl/mem_stall_ctrl_pkg.sv
// Shared opcodes, controller state encoding and the memory-op predicate
// used by the memory-hazard stall controller.
`timescale 1ns/1ps
package mem_pkg;

  localparam logic [4:0] OP_ST  = 5'b10000;
  localparam logic [4:0] OP_LD  = 5'b10001;
  localparam logic [4:0] OP_NOP = 5'b00001;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  function automatic logic is_memop(input logic [4:0] op, input logic valid);
    return valid && ((op == OP_ST) || (op == OP_LD));
  endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the stall controller.
// The master drives IF/ID status, flush and mem_ack; the slave is the controller.
`timescale 1ns/1ps
interface mem_stall_ctrl_if;

  logic [4:0] ifid_op;
  logic       ifid_valid;
  logic       flush;
  logic       mem_ack;
  logic       stall_pc;
  logic       stall_ifid;
  logic       bubble_idex;
  logic       freeze;
  logic       mem_req;
  logic       mem_we;
  logic       hazard;
  logic       err;

  modport master (
    output ifid_op, ifid_valid, flush, mem_ack,
    input  stall_pc, stall_ifid, bubble_idex, freeze, mem_req, mem_we, hazard, err
  );

  modport slave (
    input  ifid_op, ifid_valid, flush, mem_ack,
    output stall_pc, stall_ifid, bubble_idex, freeze, mem_req, mem_we, hazard, err
  );

endinterface

// File: rtl/mem_stall_ctrl_shadow.sv
// Shadow copy of opcode/valid for ID/EX, EX/MEM and MEM/WB.
// Shifts one stage per cycle unless held; ID/EX can be loaded with a bubble.
`timescale 1ns/1ps
module mem_shadow_pipe
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic       bubble,
  input  logic [4:0] in_op,
  input  logic       in_valid,
  output logic [4:0] op_idex,
  output logic       v_idex,
  output logic [4:0] op_exmem,
  output logic       v_exmem,
  output logic [4:0] op_memwb,
  output logic       v_memwb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_idex  <= OP_NOP;
      v_idex   <= 1'b0;
      op_exmem <= OP_NOP;
      v_exmem  <= 1'b0;
      op_memwb <= OP_NOP;
      v_memwb  <= 1'b0;
    end else if (!hold) begin
      op_memwb <= op_exmem;
      v_memwb  <= v_exmem;
      op_exmem <= op_idex;
      v_exmem  <= v_idex;
      op_idex  <= bubble ? OP_NOP : in_op;
      v_idex   <= bubble ? 1'b0 : in_valid;
    end
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Memory-op hazard resolver: structural ld/st stall, data-memory handshake
// for the op in EX/MEM, whole-pipeline freeze and sticky timeout error.
`timescale 1ns/1ps
module mem_stall_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_stall_ctrl_if.slave    bus
);

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       err_q;

  logic [4:0] op_idex, op_exmem, op_memwb;
  logic       v_idex, v_exmem, v_memwb;
  logic       mem_ifid, mem_idex, mem_exmem, mem_memwb, older_mem;
  logic       mem_req, freeze, sid;

  assign mem_ifid  = is_memop(bus.ifid_op, bus.ifid_valid);
  assign mem_idex  = is_memop(op_idex, v_idex);
  assign mem_exmem = is_memop(op_exmem, v_exmem);
  assign mem_memwb = is_memop(op_memwb, v_memwb);
  assign older_mem = mem_idex | mem_exmem | mem_memwb;

  // mem_req depends only on registered state, so mem_ack never reaches it
  assign mem_req = mem_exmem & (state != ST_ERR);
  assign freeze  = (state == ST_ERR) | (mem_req & ~bus.mem_ack);
  assign sid     = mem_ifid & older_mem & ~bus.flush & ~freeze;

  assign bus.stall_pc    = freeze | sid;
  assign bus.stall_ifid  = freeze | sid;
  assign bus.bubble_idex = sid;
  assign bus.freeze      = freeze;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_req & (op_exmem == OP_ST);
  assign bus.hazard      = mem_ifid | older_mem;
  assign bus.err         = err_q;

  mem_shadow_pipe u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (freeze),
    .bubble   (sid | bus.flush),
    .in_op    (bus.ifid_op),
    .in_valid (bus.ifid_valid),
    .op_idex  (op_idex),
    .v_idex   (v_idex),
    .op_exmem (op_exmem),
    .v_exmem  (v_exmem),
    .op_memwb (op_memwb),
    .v_memwb  (v_memwb)
  );

  // The first unacked cycle happens in RUN, so reaching TIMEOUT-1 in WAIT
  // means TIMEOUT consecutive frozen cycles before the error is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !bus.mem_ack) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_M1) begin
            state <= ST_ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ERR: begin
          err_q <= 1'b1;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: a pipeline-level reference model predicts
// each cycle's outputs into a queue that an independent monitor drains and compares.
`timescale 1ns/1ps
module tb_mem_stall_ctrl;
  import mem_pkg::*;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;

  mem_stall_ctrl_if bus ();

  mem_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] op;
    logic       valid;
  } slot_t;

  // pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB
  slot_t      pipe[3];
  bit         err_flag;
  int         unacked;
  logic [7:0] exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;

  function automatic bit mem_instr(input logic [4:0] op, input logic valid);
    return valid && (op == 5'b10000 || op == 5'b10001);
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 3; i++) pipe[i] = '{5'b00001, 1'b0};
    err_flag = 1'b0;
    unacked  = 0;
  endtask

  // Output vector order: stall_pc stall_ifid bubble_idex freeze mem_req mem_we hazard err
  task automatic checkOutput(input string name, input logic [7:0] expected);
    logic [7:0] actual;
    actual = {bus.stall_pc, bus.stall_ifid, bus.bubble_idex, bus.freeze,
              bus.mem_req, bus.mem_we, bus.hazard, bus.err};
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  // One pipeline cycle: predict this cycle's outputs, then advance the model
  task automatic applyStimulus(input logic [4:0] op, input logic valid,
                               input logic fl, input logic ack);
    bit older, req, frz, sid;
    @(negedge clk);
    bus.ifid_op    = op;
    bus.ifid_valid = valid;
    bus.flush      = fl;
    bus.mem_ack    = ack;
    older = 1'b0;
    for (int i = 0; i < 3; i++) older |= mem_instr(pipe[i].op, pipe[i].valid);
    req = mem_instr(pipe[1].op, pipe[1].valid) && !err_flag;
    frz = err_flag || (req && !ack);
    sid = !frz && !fl && mem_instr(op, valid) && older;
    exp_q.push_back({frz | sid, frz | sid, sid, frz, req,
                     req && (pipe[1].op == 5'b10000),
                     mem_instr(op, valid) || older, err_flag});
    if (!err_flag) begin
      if (req && !ack) begin
        unacked++;
        if (unacked == TIMEOUT) err_flag = 1'b1;
      end else begin
        unacked = 0;
      end
    end
    if (!frz) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (sid || fl) ? '{5'b00001, 1'b0} : '{op, valid};
    end
  endtask

  task automatic idle(input logic ack);
    applyStimulus(OP_NOP, 1'b0, 1'b0, ack);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic doReset(input logic [4:0] op, input logic valid);
    bus.ifid_op    = op;
    bus.ifid_valid = valid;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("async_reset", {6'b000000, mem_instr(op, valid), 1'b0});
    bus.ifid_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic midReset();
    @(posedge clk);
    #3;
    doReset(OP_LD, 1'b1);
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("cycle", e);
      end
    end
  end

  initial begin : driver
    logic [4:0] rop;
    int guard;
    doReset(OP_LD, 1'b1);

    // back-to-back load then store: three stall cycles, then store issues
    applyStimulus(OP_LD, 1'b1, 1'b0, 1'b1);
    repeat (5) applyStimulus(OP_ST, 1'b1, 1'b0, 1'b1);
    repeat (4) idle(1'b1);

    // load with three wait cycles
    applyStimulus(OP_LD, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    repeat (3) idle(1'b0);
    idle(1'b1);
    repeat (3) idle(1'b1);

    // flush beats the structural stall
    applyStimulus(OP_LD, 1'b1, 1'b0, 1'b1);
    applyStimulus(OP_ST, 1'b1, 1'b1, 1'b1);
    repeat (4) idle(1'b1);

    // flush while frozen is ignored
    applyStimulus(OP_LD, 1'b1, 1'b0, 1'b1);
    applyStimulus(OP_ST, 1'b1, 1'b0, 1'b1);
    applyStimulus(OP_ST, 1'b1, 1'b1, 1'b0);
    applyStimulus(OP_ST, 1'b1, 1'b1, 1'b0);
    applyStimulus(OP_ST, 1'b1, 1'b0, 1'b1);
    repeat (5) idle(1'b1);

    // reset in the middle of a wait
    applyStimulus(OP_LD, 1'b1, 1'b0, 1'b1);
    repeat (5) idle(1'b0);
    midReset();

    // timeout: ack never arrives, error is sticky until reset
    applyStimulus(OP_ST, 1'b1, 1'b0, 1'b1);
    repeat (22) applyStimulus(OP_LD, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    repeat (3) applyStimulus(OP_LD, 1'b1, 1'b0, 1'b1);
    midReset();

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0:       rop = OP_LD;
        1:       rop = OP_ST;
        2:       rop = OP_NOP;
        default: rop = 5'($urandom);
      endcase
      applyStimulus(rop, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 9) < 7));
      if (n % 250 == 249) midReset();
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      #3;
      guard++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
